// File: rtl/systolic_scheduler_pkg.sv
// Shared sizing constants and scheduler state encoding for the systolic scheduler.
package systolic_scheduler_pkg;

   localparam int N                = 16;
   localparam int LOG_N            = 4;
   localparam int BP_WIDTH         = 2;
   localparam int ADDRESS_WIDTH    = 10;
   localparam int MEM_AMOUNT_WIDTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      LOAD,
      STREAM,
      DRAIN
   } state_t;

endpackage

// File: rtl/systolic_scheduler_seq_fetch.sv
// Buffer address counter with a 1-cycle qualifier register matching the buffer read latency.
module seq_fetch
   import systolic_scheduler_pkg::*;
#(
   parameter int AW = 10,
   parameter int BW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic [AW-1:0] i_base,
   input  logic          i_issue,
   input  logic          i_mask,
   input  logic [BW-1:0] i_data,
   output logic [AW-1:0] o_addr,
   output logic [BW-1:0] o_data,
   output logic          o_qual
);

   logic [AW-1:0] r_addr;
   logic          r_qual;
   logic          r_mask;

   // Address counter: preset at pass start, advances once per issued beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_base;
      end else if (i_issue) begin
         r_addr <= r_addr + 1'b1;
      end
   end

   // Qualifier and mask delayed one cycle so they line up with the returned buffer data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_qual <= 1'b0;
         r_mask <= 1'b0;
      end else begin
         r_qual <= i_issue;
         r_mask <= i_mask;
      end
   end

   assign o_addr = r_addr;
   assign o_qual = r_qual;
   assign o_data = (r_qual && !r_mask) ? i_data : '0;

endmodule

// File: rtl/systolic_scheduler.sv
// Pass-level sequencer: slices the query into N-base chunks and runs one array pass per chunk.
module systolic_scheduler
   import systolic_scheduler_pkg::*;
#(
   parameter int N                = systolic_scheduler_pkg::N,
   parameter int LOG_N            = systolic_scheduler_pkg::LOG_N,
   parameter int BP_WIDTH         = systolic_scheduler_pkg::BP_WIDTH,
   parameter int ADDRESS_WIDTH    = systolic_scheduler_pkg::ADDRESS_WIDTH,
   parameter int MEM_AMOUNT_WIDTH = systolic_scheduler_pkg::MEM_AMOUNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset_i,
   input  logic                        start,
   input  logic [ADDRESS_WIDTH-1:0]    q_len,
   input  logic [ADDRESS_WIDTH-1:0]    t_len,
   output logic [ADDRESS_WIDTH-1:0]    q_addr,
   input  logic [BP_WIDTH-1:0]         q_data,
   output logic [ADDRESS_WIDTH-1:0]    t_addr,
   input  logic [BP_WIDTH-1:0]         t_data,
   output logic [BP_WIDTH-1:0]         S,
   output logic [BP_WIDTH-1:0]         T,
   output logic                        s_update,
   output logic                        valid,
   output logic                        ack,
   output logic                        new_seq,
   output logic [LOG_N-1:0]            PE_end,
   input  logic                        array_busy,
   output logic [MEM_AMOUNT_WIDTH-1:0] pass_idx,
   output logic                        sched_busy,
   output logic                        done,
   output logic                        err
);

   localparam logic [LOG_N:0] C_LAST_K = (LOG_N+1)'(N-1);

   state_t                      r_state, w_next;
   logic [ADDRESS_WIDTH-1:0]    r_q_len, r_t_len;
   logic [MEM_AMOUNT_WIDTH:0]   r_npass;
   logic [LOG_N-1:0]            r_last_end, r_pe_end;
   logic [MEM_AMOUNT_WIDTH-1:0] r_pass;
   logic [LOG_N:0]              r_kcnt;
   logic                        r_seen, r_done, r_err;

   logic [ADDRESS_WIDTH-1:0]    w_qm1, w_npass, w_q_addr, w_t_addr, w_q_base;
   logic                        w_bad, w_last, w_q_mask;
   logic                        w_accept, w_reject, w_finish, w_advance;
   logic                        w_ack, w_new_seq, w_load, w_q_issue, w_t_issue;

   assign w_qm1    = q_len - 1'b1;
   assign w_npass  = (w_qm1 >> LOG_N) + 1'b1;
   assign w_bad    = (q_len == '0) || (t_len == '0) ||
                     (w_npass > ADDRESS_WIDTH'(2**MEM_AMOUNT_WIDTH));
   assign w_last   = ({1'b0, r_pass} == (r_npass - 1'b1));
   assign w_q_base = ADDRESS_WIDTH'(r_pass) << LOG_N;
   assign w_q_mask = (w_q_addr >= r_q_len);

   seq_fetch #(.AW(ADDRESS_WIDTH), .BW(BP_WIDTH)) u_q_fetch (
      .clk     (clk),
      .rst_n   (reset_i),
      .i_load  (w_load),
      .i_base  (w_q_base),
      .i_issue (w_q_issue),
      .i_mask  (w_q_mask),
      .i_data  (q_data),
      .o_addr  (w_q_addr),
      .o_data  (S),
      .o_qual  (s_update)
   );

   seq_fetch #(.AW(ADDRESS_WIDTH), .BW(BP_WIDTH)) u_t_fetch (
      .clk     (clk),
      .rst_n   (reset_i),
      .i_load  (w_load),
      .i_base  ('0),
      .i_issue (w_t_issue),
      .i_mask  (1'b0),
      .i_data  (t_data),
      .o_addr  (w_t_addr),
      .o_data  (T),
      .o_qual  (valid)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      w_next    = r_state;
      w_ack     = 1'b0;
      w_new_seq = 1'b0;
      w_load    = 1'b0;
      w_q_issue = 1'b0;
      w_t_issue = 1'b0;
      w_accept  = 1'b0;
      w_reject  = 1'b0;
      w_finish  = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_bad) begin
                  w_reject = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  w_next   = START;
               end
            end
         end
         START: begin
            w_ack     = 1'b1;
            w_new_seq = (r_pass == '0);
            w_load    = 1'b1;
            w_next    = LOAD;
         end
         LOAD: begin
            w_q_issue = 1'b1;
            if (r_kcnt == C_LAST_K) w_next = STREAM;
         end
         STREAM: begin
            w_t_issue = 1'b1;
            w_ack     = 1'b1;
            if (w_t_addr == r_t_len - 1'b1) w_next = DRAIN;
         end
         DRAIN: begin
            if (r_seen && !array_busy) begin
               if (w_last) begin
                  w_finish = 1'b1;
                  w_next   = IDLE;
               end else begin
                  w_advance = 1'b1;
                  w_next    = START;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Job parameters, pass bookkeeping and the registered done/err pulses.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_q_len    <= '0;
         r_t_len    <= '0;
         r_npass    <= '0;
         r_last_end <= '0;
         r_pe_end   <= '0;
         r_pass     <= '0;
         r_kcnt     <= '0;
         r_seen     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= w_finish;
         r_err  <= w_reject;
         if (w_accept) begin
            r_q_len    <= q_len;
            r_t_len    <= t_len;
            r_npass    <= w_npass[MEM_AMOUNT_WIDTH:0];
            r_last_end <= w_qm1[LOG_N-1:0];
            r_pass     <= '0;
         end
         if (r_state == START) begin
            r_pe_end <= w_last ? r_last_end : '1;
            r_kcnt   <= '0;
            r_seen   <= 1'b0;
         end
         if (r_state == LOAD) r_kcnt <= r_kcnt + 1'b1;
         if (r_state == DRAIN && array_busy) r_seen <= 1'b1;
         if (w_advance) r_pass <= r_pass + 1'b1;
      end
   end

   assign q_addr     = w_q_addr;
   assign t_addr     = w_t_addr;
   assign ack        = w_ack;
   assign new_seq    = w_new_seq;
   assign PE_end     = r_pe_end;
   assign pass_idx   = r_pass;
   assign sched_busy = (r_state != IDLE);
   assign done       = r_done;
   assign err        = r_err;

endmodule
